// File: rtl/mips_alu_seq_if.sv
// Issue/result bundle for the MIPS sequential ALU.
// The master drives the operation; the slave (the ALU) returns the result, the flags and HI/LO.
interface mips_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  result, zero, overflow, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output result, zero, overflow, busy, done, hi, lo
  );
endinterface

// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU. Single-cycle ops complete one edge after issue.
// MULTU and DIVU are iterative: shift-add or restoring divide, one bit per edge
// over WIDTH edges. HI and LO are written only when a MULTU or DIVU completes.
module mips_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_alu_seq_if.slave bus
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_opnd;    // multiplicand or divisor
  logic [2*WIDTH-1:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  assign w_sum = bus.a + bus.b;
  assign w_dif = bus.a - bus.b;

  // Single-cycle datapath: result and overflow for the op being issued now.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.op)
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_NOR:  w_res = ~(bus.a | bus.b);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  w_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: w_res = WIDTH'(bus.a < bus.b);
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  // One multiply or divide step. The multiply adds the multiplicand into the
  // upper half when the multiplier LSB is set, then shifts right with the carry.
  // The divide shifts in the next dividend bit, MSB first, and keeps the
  // difference only when it does not borrow. A zero divisor never borrows, so
  // the quotient becomes all ones and the remainder becomes the dividend.
  always_comb begin
    w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};
    w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_shift - {1'b0, r_opnd};
    w_div_nxt = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                              : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
  end

  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

  // Control FSM with registered outputs. done is a single-cycle strobe per completed op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MULTU || bus.op == OP_DIVU) begin
              r_acc    <= {{WIDTH{1'b0}}, bus.a};
              r_opnd   <= bus.b;
              r_is_div <= (bus.op == OP_DIVU);
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_RUN;
            end else begin
              r_result <= w_res;
              r_ovf    <= w_ovf;
              r_done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi     <= w_acc_nxt[2*WIDTH-1:WIDTH];
            r_lo     <= w_acc_nxt[WIDTH-1:0];
            r_result <= w_acc_nxt[WIDTH-1:0];
            r_ovf    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.zero     = (r_result == '0);
  assign bus.overflow = r_ovf;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Randomised self-checking bench for mips_alu_seq (WIDTH=32) against a plain-arithmetic model.
module tb_mips_alu_seq;
  localparam int W = 32;
  localparam logic [3:0] ADD = 4'd2, SUB = 4'd6, SLT = 4'd7, SLTU = 4'd5, NOR = 4'd4;
  localparam logic [3:0] MULTU = 4'd8, DIVU = 4'd9, MFHI = 4'd10, MFLO = 4'd11;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mips_alu_seq_if #(.WIDTH(W)) bus ();
  mips_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference for the single-cycle ops, computed from signed/unsigned integer arithmetic.
  function automatic void model_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] r, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    v = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = ~(a | b);
      4'd2: begin s = sa + sb; r = W'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6: begin s = sa - sb; r = W'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7: r = (sa < sb) ? 1 : 0;
      4'd5: r = (a < b) ? 1 : 0;
      4'd10: r = m_hi;
      4'd11: r = m_lo;
      default: r = '0;
    endcase
  endfunction

  // Drive an op for one accept edge, then scramble the operands to show they are not reused.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'($urandom_range(0, 15)); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic do_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic v;
    model_single(op, a, b, r, v);
    issue(op, a, b);
    chk($sformatf("res op%0d", op), bus.result, r);
    chk($sformatf("ovf op%0d", op), bus.overflow, v);
    chk("done single", bus.done, 1);
    chk("zero", bus.zero, (r == 0));
    chk("hi kept", bus.hi, m_hi);
    chk("lo kept", bus.lo, m_lo);
  endtask

  task automatic do_multi(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [63:0] p;
    int n;
    if (op == MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (b == 0) begin
      m_hi = a; m_lo = '1;
    end else begin
      m_hi = a % b; m_lo = a / b;
    end
    issue(op, a, b);
    chk("busy after accept", bus.busy, 1);
    n = 0;
    while (!bus.done && n < 100) begin
      if (inject && n == 4) begin bus.start = 1'b1; bus.op = ADD; bus.a = 32'd1; bus.b = 32'd2; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk("latency", n, W);
    chk("busy at done", bus.busy, 0);
    chk("md hi", bus.hi, m_hi);
    chk("md lo", bus.lo, m_lo);
    chk("md result", bus.result, m_lo);
    chk("md ovf", bus.overflow, 0);
    if (inject) begin
      @(posedge clk); #1;
      chk("single done pulse", bus.done, 0);
    end
  endtask

  initial begin
    logic [3:0] sops [10] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd2, 4'd6, 4'd7, 4'd5, 4'd10, 4'd11};
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #10;
    chk("rst result", bus.result, 0);
    chk("rst zero", bus.zero, 1);
    chk("rst ovf", bus.overflow, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst hi", bus.hi, 0);
    chk("rst lo", bus.lo, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle cases.
    do_single(ADD, 32'h7FFFFFFF, 32'h1);
    do_single(SUB, 32'd5, 32'd5);
    do_single(SLT, 32'hFFFFFFFF, 32'h1);
    do_single(SLTU, 32'hFFFFFFFF, 32'h1);
    do_single(NOR, 32'h0, 32'h0);
    do_single(4'hF, 32'h1234, 32'h5678);
    do_single(SUB, 32'h80000000, 32'h1);

    // Directed multi-cycle cases.
    do_multi(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_single(MFHI, 32'h0, 32'h0);
    do_multi(DIVU, 32'd100, 32'd7, 1'b0);
    do_single(MFLO, 32'h0, 32'h0);
    do_multi(DIVU, 32'h12345678, 32'h0, 1'b0);

    // Ignored start while busy, then accept in the done cycle and back-to-back single ops.
    do_multi(MULTU, 32'h0001_0003, 32'h0000_0101, 1'b1);
    do_multi(DIVU, 32'hDEADBEEF, 32'h00000123, 1'b0);
    do_single(ADD, 32'h0000_0010, 32'h0000_0020);
    do_single(MFHI, 32'h0, 32'h0);

    // Random single-cycle traffic, issued back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = ra;
      do_single((i % 9 == 8) ? 4'($urandom_range(12, 15)) : sops[$urandom_range(0, 9)], ra, rb);
    end

    // Random multiply/divide, including zero divisors.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = (i == 3) ? 32'd0 : (i % 2 ? 32'($urandom_range(1, 1000)) : $urandom);
      do_multi((i % 2) ? DIVU : MULTU, ra, rb, 1'b0);
      do_single(MFHI, 32'h0, 32'h0);
      do_single(MFLO, 32'h0, 32'h0);
    end

    // Reset in the middle of a DIVU aborts without a done pulse.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort result", bus.result, 0);
    chk("abort zero", bus.zero, 1);
    chk("abort hi", bus.hi, 0);
    chk("abort lo", bus.lo, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no done", bus.done, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle done", bus.done, 0);
    do_single(ADD, 32'd40, 32'd2);
    do_single(MFLO, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Registered, parametrised ALU with an iterative unsigned multiply/divide unit and HI/LO registers, for the MIPS datapath. Single-cycle logic/arith/compare ops complete one edge after issue. MULTU/DIVU run a shift-add / restoring-divide engine over WIDTH cycles under a start/busy/done handshake. The control unit stalls on busy.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue strobe; sampled only when busy=0
- op  in  4  operation code (see Operation)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate)
- result  out  WIDTH  registered result
- zero  out  1  result == 0 (combinational from result register)
- overflow  out  1  signed overflow of last ADD/SUB; 0 for all other ops
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: result (and HI/LO if mul/div) updated
- hi  out  WIDTH  HI register (mul high word / remainder)
- lo  out  WIDTH  LO register (mul low word / quotient)

## Operation
- Opcodes, single-cycle: 0000 AND, 0001 OR, 0011 XOR, 0100 NOR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLTU (unsigned), 1010 MFHI (result=hi), 1011 MFLO (result=lo).
- Opcodes, multi-cycle: 1000 MULTU, 1001 DIVU. Unknown opcodes: result=0, overflow=0, done pulses.
- SLT/SLTU write 1 or 0 zero-extended to WIDTH.
- ADD/SUB wrap modulo 2^WIDTH.
- overflow for ADD: a, b same sign and sum sign differs. For SUB: a, b differ in sign and diff sign differs from a.
- States:
  - IDLE: start with single-cycle op → latch result/overflow, pulse done, stay IDLE. Start with MULTU/DIVU → load operands, clear partial product/remainder, count=0, go RUN.
  - RUN: one iteration per edge. MULTU uses a 2·WIDTH shift-add. DIVU uses restoring division, MSB first. Unknown ops are not accepted into RUN.
  - Last iteration (count = WIDTH−1): write hi/lo, result=lo, overflow=0, pulse done, go IDLE.
- DIVU by zero uses no special path. Restoring divide naturally yields lo = all ones and hi = a, with the same latency.
- start while busy=1 is ignored. No state change and no queuing.
- hi/lo change only at MULTU/DIVU completion. Single-cycle ops never touch them.
- MFHI/MFLO issued on the completion edge's following cycle read the new values.

## Timing
- Reset (async assert, sync-safe deassert): result=0, zero=1, overflow=0, busy=0, done=0, hi=0, lo=0, state=IDLE, count=0.
- Single-cycle op accepted at edge k: result/overflow/done valid after edge k (latency 1).
  - Back-to-back issue every cycle is allowed. done stays high across consecutive ops.
- MULTU/DIVU accepted at edge k:
  - busy=1 after edge k.
  - Iterations on edges k+1 … k+WIDTH.
  - After edge k+WIDTH: busy=0, done=1, hi/lo/result valid. Latency is WIDTH edges from acceptance to done.
- start=1 in the done cycle (busy=0) is accepted. Throughput for mul/div is 1 op per WIDTH+1 cycles.
- a/b/op are needed only at the accept edge. Changes during RUN have no effect.
- Reset mid-RUN: immediate abort to reset values. The partial op is lost, done does not pulse, and hi/lo return to 0.
- Outputs are glitch-free registers, except zero (decode of result).

## Test plan
- Reset then ops, WIDTH=32:
  - ADD 0x7FFFFFFF+0x00000001 → result=0x80000000, overflow=1, done one cycle later.
  - SUB 5−5 → result=0, zero=1, overflow=0.
- Compares and logic:
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU same operands → 0.
  - NOR 0,0 → 0xFFFFFFFF.
  - Opcode 1111 → result=0, done=1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy for exactly 32 cycles after accept, then done.
  - hi=0xFFFFFFFE, lo=0x00000001.
  - MFHI next cycle → 0xFFFFFFFE.
- DIVU cases:
  - 100 ÷ 7 → lo=14, hi=2, 32-cycle latency.
  - DIVU 0x12345678 ÷ 0 → lo=0xFFFFFFFF, hi=0x12345678.
- Handshake:
  - start=ADD pulsed at cycle 5 of a MULTU is ignored: result and hi/lo unaffected, only one done pulse.
  - start in the done cycle is accepted.
- rst_n low at cycle 10 of a DIVU → all outputs go to reset values immediately, with no done pulse. After release, a new ADD works normally.
